// File: rtl/regfile_pkg.sv
// Shared definitions for the register file: write-source priority encoding
// and default sizing constants.
package regfile_pkg;

    // Listed from highest to lowest write priority; SRC_NONE means no update.
    typedef enum logic [2:0] {
        SRC_ALU,
        SRC_DATA,
        SRC_ADDR,
        SRC_STEP,
        SRC_NONE
    } wr_src_e;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_NREGS = 4;

endpackage

// File: rtl/regfile_wr_arb.sv
// Per-register write arbiter: picks the highest-priority request, produces the
// register's next value, and flags when two or more sources collide.
module regfile_wr_arb
    import regfile_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] cur_i,
    input  logic             alu_req_i,
    input  logic [WIDTH-1:0] alu_val_i,
    input  logic             data_req_i,
    input  logic [WIDTH-1:0] data_val_i,
    input  logic             addr_req_i,
    input  logic [WIDTH-1:0] addr_val_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output wr_src_e          src_o,
    output logic [WIDTH-1:0] next_o,
    output logic             collision_o
);

    // inc and dec together cancel out and are not a request at all.
    logic       stepReq;
    logic [2:0] nReq;

    assign stepReq = inc_i ^ dec_i;
    assign nReq    = 3'(alu_req_i) + 3'(data_req_i) + 3'(addr_req_i) + 3'(stepReq);
    assign collision_o = (nReq >= 3'd2);

    always_comb begin
        src_o  = SRC_NONE;
        next_o = cur_i;
        if (alu_req_i) begin
            src_o  = SRC_ALU;
            next_o = alu_val_i;
        end else if (data_req_i) begin
            src_o  = SRC_DATA;
            next_o = data_val_i;
        end else if (addr_req_i) begin
            src_o  = SRC_ADDR;
            next_o = addr_val_i;
        end else if (stepReq) begin
            src_o  = SRC_STEP;
            next_o = inc_i ? cur_i + WIDTH'(1) : cur_i - WIDTH'(1);
        end
    end

endmodule

// File: rtl/regfile.sv
// Multi-port register file with prioritized writes and a sticky collision flag.
// Define REGFILE_BYPASS_EN to forward same-cycle winning writes to all read ports.
module regfile
    import regfile_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    parameter  int NREGS = DEFAULT_NREGS,
    localparam int SELW  = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_data_en,
    input  logic [SELW-1:0]  rd_data_sel,
    output logic [WIDTH-1:0] out_data,
    input  logic             wr_data_en,
    input  logic [SELW-1:0]  wr_data_sel,
    input  logic [WIDTH-1:0] in_data,
    input  logic             rd_addr_en,
    input  logic [SELW-1:0]  rd_addr_sel,
    output logic [WIDTH-1:0] out_addr,
    input  logic             wr_addr_en,
    input  logic [SELW-1:0]  wr_addr_sel,
    input  logic [WIDTH-1:0] in_addr,
    input  logic [SELW-1:0]  alu_a_sel,
    input  logic [SELW-1:0]  alu_b_sel,
    output logic [WIDTH-1:0] alu_a_bus,
    output logic [WIDTH-1:0] alu_b_bus,
    input  logic             alu_w,
    input  logic [SELW-1:0]  alu_w_sel,
    input  logic [WIDTH-1:0] alu_out_bus,
    input  logic             inc,
    input  logic             dec,
    input  logic [SELW-1:0]  step_sel,
    output logic             conflict,
    input  logic             clr_conflict
);

    logic [NREGS-1:0][WIDTH-1:0] regs_q;
    logic [NREGS-1:0][WIDTH-1:0] next_d;
    logic [NREGS-1:0][WIDTH-1:0] view;
    logic [NREGS-1:0]            collision;
    wr_src_e                     src [NREGS];
    logic                        conflict_q;
    logic                        conflict_d;

    // Selects >= NREGS never match an index, so they neither write nor read.
    for (genvar i = 0; i < NREGS; i++) begin : g_reg
        localparam logic [SELW-1:0] IDX = SELW'(i);

        regfile_wr_arb #(.WIDTH(WIDTH)) u_arb (
            .cur_i       (regs_q[i]),
            .alu_req_i   (alu_w && (alu_w_sel == IDX)),
            .alu_val_i   (alu_out_bus),
            .data_req_i  (wr_data_en && (wr_data_sel == IDX)),
            .data_val_i  (in_data),
            .addr_req_i  (wr_addr_en && (wr_addr_sel == IDX)),
            .addr_val_i  (in_addr),
            .inc_i       (inc && (step_sel == IDX)),
            .dec_i       (dec && (step_sel == IDX)),
            .src_o       (src[i]),
            .next_o      (next_d[i]),
            .collision_o (collision[i])
        );
    end

    // A fresh collision outranks a clear request in the same cycle.
    assign conflict_d = (|collision) | (conflict_q & ~clr_conflict);
    assign conflict   = conflict_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q     <= '0;
            conflict_q <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (src[i] != SRC_NONE) begin
                    regs_q[i] <= next_d[i];
                end
            end
            conflict_q <= conflict_d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Reset cancels every write, so nothing is forwarded while it is high.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            view[i] = (!rst && (src[i] != SRC_NONE)) ? next_d[i] : regs_q[i];
        end
    end
`else
    assign view = regs_q;
`endif

    function automatic logic [WIDTH-1:0] readMux(input logic [SELW-1:0] sel,
                                                 input logic [NREGS-1:0][WIDTH-1:0] v);
        readMux = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (sel == SELW'(i)) begin
                readMux = v[i];
            end
        end
    endfunction

    always_comb begin
        out_data  = rd_data_en ? readMux(rd_data_sel, view) : '0;
        out_addr  = rd_addr_en ? readMux(rd_addr_sel, view) : '0;
        alu_a_bus = readMux(alu_a_sel, view);
        alu_b_bus = readMux(alu_b_sel, view);
    end

endmodule
